// File: rtl/posit_cmdq_pkg.sv
// Shared constants for the posit command queue: register map, STATUS/CTRL bit
// positions and the issue FSM state type.
package posit_cmdq_pkg;

    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_BUSY_BIT    = 0;
    localparam int ST_FULL_BIT    = 1;
    localparam int ST_EMPTY_BIT   = 2;
    localparam int ST_TIMEOUT_BIT = 3;
    localparam int ST_RVALID_BIT  = 4;
    localparam int ST_COUNT_LSB   = 8;
    localparam int ST_DONE_LSB    = 16;

    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_CLR_TO_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } cmdq_state_e;

endpackage

// File: rtl/posit_cmd_fifo.sv
// Synchronous FIFO holding queued posit command words; flush empties it and
// overrides a same-cycle pop (the popped head is still valid on head_o that cycle).
module posit_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/posit_cmd_queue.sv
// Host-side command queue bridging Ibex data-bus writes to the posit processor
// gpup_* port. Optional watchdog on WAIT enabled by defining POSIT_CMDQ_TIMEOUT_EN.
module posit_cmd_queue
    import posit_cmdq_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] GPUP_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_gnt_o,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    output logic        gpup_req_o,
    output logic [31:0] gpup_addr_o,
    output logic [31:0] gpup_wdata_o,
    input  logic        gpup_rvalid_i,
    input  logic [31:0] gpup_rdata_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    reg_idx;
    logic          host_wr;
    logic          host_rd;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          capture;
    logic          result_rd;
    logic [31:0]   status_word;
    logic [31:0]   rdata_d;
    logic          unused_addr;

    cmdq_state_e   state_q;
    logic          req_q;
    logic [31:0]   wdata_q;
    logic [31:0]   result_q;
    logic          result_valid_q;
    logic [15:0]   done_q;
    logic          host_rvalid_q;
    logic [31:0]   host_rdata_q;

    assign reg_idx     = host_addr_i[3:2];
    assign unused_addr = ^{host_addr_i[31:4], host_addr_i[1:0]};

    assign host_gnt_o = host_req_i & ~(host_we_i & (reg_idx == REG_CMD) & fifo_full);
    assign host_wr    = host_gnt_o & host_we_i;
    assign host_rd    = host_gnt_o & ~host_we_i;
    assign fifo_push  = host_wr & (reg_idx == REG_CMD);
    assign fifo_flush = host_wr & (reg_idx == REG_CTRL) & host_wdata_i[CTRL_FLUSH_BIT];
    assign fifo_pop   = (state_q == S_IDLE) & ~fifo_empty;
    assign result_rd  = host_rd & (reg_idx == REG_RESULT);
    // Completions only count while a command is actually outstanding.
    assign capture    = gpup_rvalid_i & ((state_q == S_ISSUE) | (state_q == S_WAIT));

    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rdata_q;
    assign gpup_req_o    = req_q;
    assign gpup_wdata_o  = wdata_q;
    assign gpup_addr_o   = GPUP_ADDR;

    posit_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (host_wdata_i),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef POSIT_CMDQ_TIMEOUT_EN
    localparam int            WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wdog_q;
    logic          timeout_q;
    logic          clr_timeout;
    assign clr_timeout = host_wr & (reg_idx == REG_CTRL) & host_wdata_i[CTRL_CLR_TO_BIT];
`endif

    always_comb begin
        status_word                        = '0;
        status_word[ST_BUSY_BIT]           = (state_q != S_IDLE) | ~fifo_empty;
        status_word[ST_FULL_BIT]           = fifo_full;
        status_word[ST_EMPTY_BIT]          = fifo_empty;
`ifdef POSIT_CMDQ_TIMEOUT_EN
        status_word[ST_TIMEOUT_BIT]        = timeout_q;
`endif
        status_word[ST_RVALID_BIT]         = result_valid_q;
        status_word[ST_COUNT_LSB +: 4]     = 4'(fifo_count);
        status_word[ST_DONE_LSB +: 16]     = done_q;
    end

    always_comb begin
        rdata_d = '0;
        if (host_rd) begin
            unique case (reg_idx)
                REG_CMD:    rdata_d = fifo_empty ? 32'h0 : fifo_head;
                REG_STATUS: rdata_d = status_word;
                REG_RESULT: rdata_d = result_q;
                default:    rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            req_q          <= 1'b0;
            wdata_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= '0;
            host_rvalid_q  <= 1'b0;
            host_rdata_q   <= '0;
`ifdef POSIT_CMDQ_TIMEOUT_EN
            wdog_q         <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            host_rvalid_q <= host_gnt_o;
            host_rdata_q  <= rdata_d;

            // A same-cycle capture overrides the read-clear below.
            if (result_rd) result_valid_q <= 1'b0;
            if (capture) begin
                result_q       <= gpup_rdata_i;
                result_valid_q <= 1'b1;
                done_q         <= done_q + 16'd1;
            end
`ifdef POSIT_CMDQ_TIMEOUT_EN
            if (clr_timeout) timeout_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        wdata_q <= fifo_head;
                        req_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    req_q   <= 1'b0;
                    state_q <= gpup_rvalid_i ? S_IDLE : S_WAIT;
`ifdef POSIT_CMDQ_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                S_WAIT: begin
                    if (gpup_rvalid_i) begin
                        state_q <= S_IDLE;
                    end
`ifdef POSIT_CMDQ_TIMEOUT_EN
                    else if (wdog_q == WDOG_LAST) begin
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
